lock_controller: RTL and testbench
==================================

# lock_controller

Sequencing controller for the electronic lock, placed downstream of the keypad scanner. It consumes the scanner's `Code`/`Valid` outputs, turns each key press into a single event, and collects a PIN of fixed length. It compares the PIN with a stored code and then drives unlock, lockout and alarm outputs. A program mode lets the user replace the stored code while the lock is open.

## Interface
- `PIN_LEN`, 4: digits per PIN; stored code is 4*PIN_LEN bits.
- `DEFAULT_PIN`, 16'h1234: code loaded at reset; first-entered digit in the most-significant nibble.
- `MAX_TRIES`, 3: consecutive failed entries that trigger lockout.
- `UNLOCK_CYCLES`, 8: length of the open window, and the program-mode inactivity timeout.
- `LOCKOUT_CYCLES`, 16: length of lockout.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Code`  in  4  key code from the scanner: 0-9 are digits, 10 is `*` (clear/program), 11 is `#` (enter).
- `Valid`  in  1  scanner valid; stays high for as long as the key is held.
- `unlock`  out  1  high while in OPEN.
- `prog_mode`  out  1  high while in PROG.
- `lockout`  out  1  high while in LOCKOUT.
- `alarm`  out  1  high while in LOCKOUT.
- `error`  out  1  one-cycle pulse when an entry is rejected.
- `accept`  out  1  one-cycle pulse when a new PIN is stored.
- `digit_count`  out  $clog2(PIN_LEN+1)  number of digits currently buffered.

## Operation
- **Key event:** `key_evt = Valid & ~valid_q`, where `valid_q` is `Valid` registered.
  - `Code` is sampled in the same cycle as `key_evt`. It is not valid in later cycles, because the scanner drives all columns while a key is held.
- **Entry buffer:**
  - A digit is accepted only while `digit_count < PIN_LEN`: `buf <= {buf[4*PIN_LEN-5:0], digit}` and the count increments.
  - Digits arriving when the count equals PIN_LEN are dropped.
- **States:** IDLE, OPEN, PROG, LOCKOUT.
- **IDLE:**
  - digit: buffer it.
  - `*`: clear the buffer and set the count to 0.
  - `#` with count == PIN_LEN and `buf == stored`: go to OPEN, set tries = 0.
  - Any other `#` (count short, or mismatch): pulse `error`, tries++. If tries reaches MAX_TRIES, go to LOCKOUT; otherwise stay in IDLE.
  - The buffer and count are cleared on every `#`.
- **OPEN:**
  - The timer loads UNLOCK_CYCLES on entry.
  - `#`: go to IDLE immediately.
  - `*`: go to PROG, with the buffer cleared.
  - Digits are ignored.
  - Timer expiry: go to IDLE.
- **PROG:**
  - Digits are buffered, and every key event reloads the timer.
  - `#` with count == PIN_LEN: `stored <= buf`, pulse `accept`, go to IDLE.
  - `#` with a short count: pulse `error`, keep the old code, go to IDLE.
  - `*` or timer expiry: abort to IDLE, keep the old code.
  - Failures in PROG do not increment tries.
- **LOCKOUT:**
  - The timer loads LOCKOUT_CYCLES on entry.
  - All key events are ignored; `valid_q` still tracks `Valid`.
  - Expiry: go to IDLE with tries = 0 and the buffer cleared.
- **Reset values:**
  - state = IDLE, `stored = DEFAULT_PIN`, buffer = 0, count = 0, tries = 0, timer = 0.
  - All outputs are 0.
  - `valid_q` resets to 1, so a key held across reset release is not counted as a press.

## Timing
- All outputs are registered.
- Responses appear in the cycle after the `key_evt` cycle: `unlock`, `error` and `accept` rise on the clock edge that samples `key_evt`.
- `unlock` is high for exactly UNLOCK_CYCLES cycles unless cut short by a key.
- `lockout` and `alarm` are high for exactly LOCKOUT_CYCLES cycles.
- `error` and `accept` are high for exactly one cycle.
- At most one key event per press, however long the key is held. A new event requires `Valid` to drop for at least one cycle.
- A key event in the same cycle as timer expiry: the key wins in OPEN and PROG.
- `reset` overrides everything, including a coincident key event.
- `digit_count` updates one cycle after `key_evt`.

## Test plan
- Reset, then press 1,2,3,4,# (Valid high 3 cycles, low 2 cycles per key) -> `unlock` rises the cycle after `#` is sampled and stays high for 8 cycles; `digit_count` steps 1,2,3,4,0.
- Press 1,2,3,5,# three times -> `error` pulses three times; after the third, `lockout` and `alarm` are high for 16 cycles. Keys pressed during lockout produce no `digit_count` change. Afterwards 1,2,3,4,# unlocks.
- Press 1,2,*,1,2,3,4,# -> `*` clears the count to 0, then `unlock` asserts. Press 1,2,3,4,5,# -> the fifth digit is dropped and `unlock` asserts.
- Unlock, press `*`, then 9,8,7,6,# -> `prog_mode` high, `accept` pulses once. After that, 1,2,3,4,# gives `error` and 9,8,7,6,# gives `unlock`.
- In PROG, press 5,5,# -> `error`, old code kept. Enter PROG and wait 8 idle cycles -> return to IDLE, code unchanged.
- Hold `Valid` high for 20 cycles with `Code` = 1 -> `digit_count` = 1. Assert `reset` mid-entry with `Valid` high -> all outputs 0 next cycle, and no digit is counted on reset release.

Source files
------------

// File: rtl/lock_controller_if.sv
// Scanner-facing and lock-output signals of the lock controller, grouped as one bundle.
// The scanner side (master) drives Code/Valid; the controller side (slave) drives the status outputs.
interface lock_controller_if #(
  parameter int PIN_LEN = 4
);
  localparam int CW = $clog2(PIN_LEN + 1);

  // Valid is a level: high for as long as the key is held. There is no ready;
  // the controller treats only the rising edge of Valid as a key event.
  logic [3:0]    Code;
  logic          Valid;
  logic          unlock;
  logic          prog_mode;
  logic          lockout;
  logic          alarm;
  logic          error;
  logic          accept;
  logic [CW-1:0] digit_count;

  modport master (
    output Code, Valid,
    input  unlock, prog_mode, lockout, alarm, error, accept, digit_count
  );

  modport slave (
    input  Code, Valid,
    output unlock, prog_mode, lockout, alarm, error, accept, digit_count
  );
endinterface

// File: rtl/lock_controller.sv
// PIN entry sequencer for the electronic lock: edge-detects key presses, buffers digits,
// checks them against a programmable stored code and drives unlock/lockout/alarm.
module lock_controller #(
  parameter int                   PIN_LEN        = 4,
  parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN    = 16'h1234,
  parameter int                   MAX_TRIES      = 3,
  parameter int                   UNLOCK_CYCLES  = 8,
  parameter int                   LOCKOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  lock_controller_if.slave   bus,
  output logic [1:0]         state_o
);
  localparam int BW   = 4 * PIN_LEN;
  localparam int CW   = $clog2(PIN_LEN + 1);
  localparam int TRW  = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_PROG, S_LOCKOUT} state_t;

  state_t         state_q;
  logic           valid_q;
  logic [BW-1:0]  stored_q;
  logic [BW-1:0]  buf_q;
  logic [CW-1:0]  count_q;
  logic [TRW-1:0] tries_q;
  logic [TW-1:0]  timer_q;
  logic           unlock_q, prog_q, lock_q, error_q, accept_q;

  logic          key_evt, is_digit, is_star, is_hash, full, timer_exp;
  logic [BW-1:0] buf_shift;

  assign key_evt   = bus.Valid & ~valid_q;
  assign is_digit  = (bus.Code <= 4'd9);
  assign is_star   = (bus.Code == 4'd10);
  assign is_hash   = (bus.Code == 4'd11);
  assign full      = (count_q == CW'(PIN_LEN));
  assign buf_shift = {buf_q[BW-5:0], bus.Code};
  // The timer counts the remaining cycles of the current window; the last one is 1.
  assign timer_exp = (timer_q <= TW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b1;
      stored_q <= DEFAULT_PIN;
      buf_q    <= '0;
      count_q  <= '0;
      tries_q  <= '0;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      prog_q   <= 1'b0;
      lock_q   <= 1'b0;
      error_q  <= 1'b0;
      accept_q <= 1'b0;
    end else begin
      valid_q  <= bus.Valid;
      error_q  <= 1'b0;
      accept_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_evt) begin
            if (is_digit && !full) begin
              buf_q   <= buf_shift;
              count_q <= count_q + CW'(1);
            end else if (is_star) begin
              buf_q   <= '0;
              count_q <= '0;
            end else if (is_hash) begin
              buf_q   <= '0;
              count_q <= '0;
              if (full && buf_q == stored_q) begin
                state_q  <= S_OPEN;
                unlock_q <= 1'b1;
                tries_q  <= '0;
                timer_q  <= TW'(UNLOCK_CYCLES);
              end else begin
                error_q <= 1'b1;
                tries_q <= tries_q + TRW'(1);
                if (tries_q == TRW'(MAX_TRIES - 1)) begin
                  state_q <= S_LOCKOUT;
                  lock_q  <= 1'b1;
                  timer_q <= TW'(LOCKOUT_CYCLES);
                end
              end
            end
          end
        end
        S_OPEN: begin
          if (key_evt && is_hash) begin
            state_q  <= S_IDLE;
            unlock_q <= 1'b0;
            timer_q  <= '0;
          end else if (key_evt && is_star) begin
            state_q  <= S_PROG;
            unlock_q <= 1'b0;
            prog_q   <= 1'b1;
            timer_q  <= TW'(UNLOCK_CYCLES);
            buf_q    <= '0;
            count_q  <= '0;
          end else if (timer_exp) begin
            state_q  <= S_IDLE;
            unlock_q <= 1'b0;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_PROG: begin
          if (key_evt) begin
            timer_q <= TW'(UNLOCK_CYCLES);
            if (is_digit && !full) begin
              buf_q   <= buf_shift;
              count_q <= count_q + CW'(1);
            end else if (is_star || is_hash) begin
              state_q <= S_IDLE;
              prog_q  <= 1'b0;
              timer_q <= '0;
              buf_q   <= '0;
              count_q <= '0;
              if (is_hash && full) begin
                stored_q <= buf_q;
                accept_q <= 1'b1;
              end else if (is_hash) begin
                error_q <= 1'b1;
              end
            end
          end else if (timer_exp) begin
            state_q <= S_IDLE;
            prog_q  <= 1'b0;
            timer_q <= '0;
            buf_q   <= '0;
            count_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_LOCKOUT: begin
          if (timer_exp) begin
            state_q <= S_IDLE;
            lock_q  <= 1'b0;
            tries_q <= '0;
            timer_q <= '0;
            buf_q   <= '0;
            count_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.unlock      = unlock_q;
  assign bus.prog_mode   = prog_q;
  assign bus.lockout     = lock_q;
  assign bus.alarm       = lock_q;
  assign bus.error       = error_q;
  assign bus.accept      = accept_q;
  assign bus.digit_count = count_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed key sequences plus random presses, every cycle
// checked against an event-level model that tracks mode, entered digits and deadlines.
module tb_lock_controller;
  localparam int PIN_LEN = 4;
  localparam int MAX_TRIES = 3;
  localparam int UNLOCK = 8;
  localparam int LOCKOUT = 16;
  localparam int M_IDLE = 0, M_OPEN = 1, M_PROG = 2, M_LOCK = 3;

  logic       clock;
  logic       reset;
  logic [1:0] state_dbg;

  lock_controller_if #(.PIN_LEN(PIN_LEN)) bus ();

  lock_controller #(
    .PIN_LEN(PIN_LEN), .DEFAULT_PIN(16'h1234), .MAX_TRIES(MAX_TRIES),
    .UNLOCK_CYCLES(UNLOCK), .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .state_o(state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_unlock, cnt_lock, cnt_alarm, cnt_err, cnt_acc;

  // reference model state
  int m_mode, m_stored, m_tries, m_deadline, m_cyc;
  int m_entry[$];
  bit m_prev_valid;
  bit e_error, e_accept;

  function automatic int entry_value();
    int v = 0;
    foreach (m_entry[i]) v = v * 16 + m_entry[i];
    return v;
  endfunction

  task automatic model_step();
    bit evt;
    int c;
    m_cyc++;
    e_error = 0;
    e_accept = 0;
    if (reset) begin
      m_mode = M_IDLE; m_stored = 'h1234; m_tries = 0; m_deadline = 0;
      m_entry.delete();
      m_prev_valid = 1;
      return;
    end
    evt = bus.Valid && !m_prev_valid;
    m_prev_valid = bus.Valid;
    c = int'(bus.Code);
    case (m_mode)
      M_IDLE: if (evt) begin
        if (c <= 9) begin
          if (m_entry.size() < PIN_LEN) m_entry.push_back(c);
        end else if (c == 10) begin
          m_entry.delete();
        end else if (c == 11) begin
          if (m_entry.size() == PIN_LEN && entry_value() == m_stored) begin
            m_mode = M_OPEN; m_deadline = m_cyc + UNLOCK; m_tries = 0;
          end else begin
            e_error = 1;
            m_tries++;
            if (m_tries >= MAX_TRIES) begin
              m_mode = M_LOCK; m_deadline = m_cyc + LOCKOUT;
            end
          end
          m_entry.delete();
        end
      end
      M_OPEN: begin
        if (evt && c == 11) m_mode = M_IDLE;
        else if (evt && c == 10) begin
          m_mode = M_PROG; m_deadline = m_cyc + UNLOCK; m_entry.delete();
        end else if (m_cyc >= m_deadline) m_mode = M_IDLE;
      end
      M_PROG: begin
        if (evt) begin
          m_deadline = m_cyc + UNLOCK;
          if (c <= 9) begin
            if (m_entry.size() < PIN_LEN) m_entry.push_back(c);
          end else if (c == 10 || c == 11) begin
            if (c == 11 && m_entry.size() == PIN_LEN) begin
              m_stored = entry_value(); e_accept = 1;
            end else if (c == 11) e_error = 1;
            m_mode = M_IDLE;
            m_entry.delete();
          end
        end else if (m_cyc >= m_deadline) begin
          m_mode = M_IDLE; m_entry.delete();
        end
      end
      default: begin
        if (m_cyc >= m_deadline) begin
          m_mode = M_IDLE; m_tries = 0; m_entry.delete();
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("unlock", 32'(bus.unlock), 32'(m_mode == M_OPEN));
    chk("prog_mode", 32'(bus.prog_mode), 32'(m_mode == M_PROG));
    chk("lockout", 32'(bus.lockout), 32'(m_mode == M_LOCK));
    chk("alarm", 32'(bus.alarm), 32'(m_mode == M_LOCK));
    chk("error", 32'(bus.error), 32'(e_error));
    chk("accept", 32'(bus.accept), 32'(e_accept));
    chk("digit_count", 32'(bus.digit_count), 32'(m_entry.size()));
    if (bus.unlock === 1'b1) cnt_unlock++;
    if (bus.lockout === 1'b1) cnt_lock++;
    if (bus.alarm === 1'b1) cnt_alarm++;
    if (bus.error === 1'b1) cnt_err++;
    if (bus.accept === 1'b1) cnt_acc++;
  endtask

  task automatic idle(input int n);
    bus.Valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.Code = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  // Code is only meaningful on the first held cycle; afterwards it is scrambled.
  task automatic press(input int code, input int hold, input int gap);
    bus.Valid = 1'b1;
    bus.Code = 4'(code);
    tick();
    for (int i = 1; i < hold; i++) begin
      bus.Code = 4'($urandom_range(0, 15));
      tick();
    end
    idle(gap);
  endtask

  task automatic press_r(input int code);
    press(code, $urandom_range(1, 3), $urandom_range(1, 3));
  endtask

  task automatic enter(input int pin);
    for (int i = PIN_LEN - 1; i >= 0; i--) press_r((pin >> (4 * i)) & 15);
    press_r(11);
  endtask

  task automatic clr_counts();
    cnt_unlock = 0; cnt_lock = 0; cnt_alarm = 0; cnt_err = 0; cnt_acc = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.Valid = 1'b0;
    bus.Code = 4'd0;
    clr_counts();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // correct PIN opens for the full window
    clr_counts();
    press(1, 3, 2); chk("count_after_1", 32'(bus.digit_count), 32'd1);
    press(2, 3, 2); press(3, 3, 2); press(4, 3, 2);
    chk("count_after_4", 32'(bus.digit_count), 32'd4);
    press(11, 3, 2);
    idle(12);
    chk("unlock_len", 32'(cnt_unlock), 32'(UNLOCK));

    // three wrong entries lock out; keys during lockout do nothing
    clr_counts();
    for (int k = 0; k < 3; k++) enter('h1235);
    press(7, 1, 1);
    press(8, 1, 1);
    idle(20);
    chk("err_pulses", 32'(cnt_err), 32'd3);
    chk("lockout_len", 32'(cnt_lock), 32'(LOCKOUT));
    chk("alarm_len", 32'(cnt_alarm), 32'(LOCKOUT));
    clr_counts();
    enter('h1234);
    idle(12);
    chk("unlock_after_lock", 32'(cnt_unlock), 32'(UNLOCK));

    // star clears, and a fifth digit is dropped
    press_r(1); press_r(2); press_r(10);
    chk("star_clear", 32'(bus.digit_count), 32'd0);
    enter('h1234);
    idle(12);
    clr_counts();
    press_r(1); press_r(2); press_r(3); press_r(4); press_r(5);
    chk("fifth_dropped", 32'(bus.digit_count), 32'd4);
    press_r(11);
    idle(12);
    chk("unlock_5digit", 32'(cnt_unlock), 32'(UNLOCK));

    // program a new code
    clr_counts();
    enter('h1234);
    press_r(10);
    chk("in_prog", 32'(bus.prog_mode), 32'd1);
    enter('h9876);
    chk("accept_once", 32'(cnt_acc), 32'd1);
    clr_counts();
    enter('h1234);
    chk("old_code_err", 32'(cnt_err), 32'd1);
    enter('h9876);
    idle(12);
    chk("new_code_open", 32'(cnt_unlock), 32'(UNLOCK));

    // short entry in PROG, then a PROG timeout; code survives both
    clr_counts();
    enter('h9876);
    press_r(10);
    press_r(5); press_r(5); press_r(11);
    chk("prog_short_err", 32'(cnt_err), 32'd1);
    enter('h9876);
    press_r(10);
    idle(12);
    chk("prog_timeout", 32'(bus.prog_mode), 32'd0);
    enter('h9876);
    idle(12);

    // long hold counts once; reset with Valid high counts nothing
    press(1, 20, 2);
    chk("hold_count", 32'(bus.digit_count), 32'd1);
    press_r(10);
    press_r(9);
    bus.Valid = 1'b1;
    bus.Code = 4'd8;
    reset = 1'b1;
    tick();
    chk("rst_count", 32'(bus.digit_count), 32'd0);
    reset = 1'b0;
    bus.Code = 4'd3;
    tick(); tick(); tick();
    chk("rst_release_count", 32'(bus.digit_count), 32'd0);
    idle(2);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) enter(m_stored);
      else press_r($urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 20));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
